// File: rtl/float32_to_mxint8_quantizer.sv
// Streaming FP32 -> MXINT8 block encoder: collects BLOCK_SIZE floats, derives the shared
// E8M0 scale from the largest exponent, then quantizes one element per cycle into the output block.
module float32_to_mxint8_quantizer #(
    parameter int BLOCK_SIZE    = 32,
    parameter int SCALE_WIDTH   = 8,
    parameter int ELEM_WIDTH    = 8,
    parameter int FLOAT32_WIDTH = 32
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_valid,
    input  logic [FLOAT32_WIDTH-1:0]              i_float32,
    output logic                                  o_ready,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [SCALE_WIDTH-1:0]                o_scale,
    output logic [BLOCK_SIZE-1:0][ELEM_WIDTH-1:0] o_mxint8_elements,
    output logic                                  o_is_NaN,
    output logic                                  o_saturated
);

    localparam int CW = $clog2(BLOCK_SIZE);
    localparam logic [CW-1:0] LAST = CW'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        COLLECT,
        QUANT,
        OUT
    } state_t;

    state_t                   state, next_state;
    logic [CW-1:0]            count;
    logic [7:0]               max_exp;
    logic                     nan_seen;
    logic [FLOAT32_WIDTH-1:0] data_buf [BLOCK_SIZE];

    logic                     accept;
    logic [7:0]               in_exp;

    assign accept = i_valid & o_ready;
    assign in_exp = i_float32[30:23];

    // Quantization datapath for the element currently addressed by count
    logic [FLOAT32_WIDTH-1:0] cur;
    logic [7:0]               cur_exp;
    logic [8:0]               diff;
    logic [4:0]               sh;
    logic [24:0]              sig, mask, half, rem;
    logic [7:0]               q8;
    logic                     rnd;
    logic [8:0]               mag;
    logic [7:0]               mag_sat;
    logic [7:0]               signed_e;
    logic                     sat;
    logic [ELEM_WIDTH-1:0]    elem;

    always_comb begin
        cur     = data_buf[count];
        cur_exp = cur[30:23];
        sig     = {1'b0, cur_exp != 8'd0, cur[22:0]};
        diff    = {1'b0, max_exp} - {1'b0, cur_exp};
        sh      = 5'd17 + diff[4:0];
        mask    = (25'd1 << sh) - 25'd1;
        half    = 25'd1 << (sh - 5'd1);
        rem     = sig & mask;
        q8      = 8'(sig >> sh);
        rnd     = (rem > half) || ((rem == half) && q8[0]);
        mag     = {1'b0, q8} + {8'd0, rnd};
        mag_sat = mag[7:0];
        sat     = 1'b0;
        // Shifts of 26 or more (diff >= 9) always round to zero
        if ((cur_exp == 8'd0) || (diff >= 9'd9) || nan_seen) begin
            mag_sat = 8'd0;
        end else if (mag > 9'd127) begin
            mag_sat = 8'd127;
            sat     = 1'b1;
        end
        signed_e = cur[31] ? (8'd0 - mag_sat) : mag_sat;
        elem     = ELEM_WIDTH'(signed_e);
    end

    always_comb begin
        next_state = state;
        unique case (state)
            COLLECT: if (accept && (count == LAST)) next_state = QUANT;
            QUANT:   if (count == LAST) next_state = OUT;
            OUT:     if (o_valid && i_ready) next_state = COLLECT;
            default: next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= COLLECT;
            count             <= '0;
            o_ready           <= 1'b1;
            o_valid           <= 1'b0;
            o_scale           <= '0;
            o_mxint8_elements <= '0;
            o_is_NaN          <= 1'b0;
            o_saturated       <= 1'b0;
            max_exp           <= '0;
            nan_seen          <= 1'b0;
        end else begin
            state   <= next_state;
            o_ready <= (next_state == COLLECT);
            unique case (state)
                COLLECT: begin
                    if (accept) begin
                        count <= count + CW'(1);
                        if (in_exp > max_exp) max_exp <= in_exp;
                        if (in_exp == 8'hFF) nan_seen <= 1'b1;
                    end
                end
                QUANT: begin
                    o_mxint8_elements[count] <= elem;
                    if (sat) o_saturated <= 1'b1;
                    o_scale  <= nan_seen ? '1 : SCALE_WIDTH'(max_exp);
                    o_is_NaN <= nan_seen;
                    count    <= count + CW'(1);
                end
                OUT: begin
                    // o_valid rises one cycle after entering OUT
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                    end else if (i_ready) begin
                        o_valid     <= 1'b0;
                        o_is_NaN    <= 1'b0;
                        o_saturated <= 1'b0;
                        max_exp     <= '0;
                        nan_seen    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) data_buf[count] <= i_float32;
    end

endmodule

// File: tb/tb_float32_to_mxint8_quantizer.sv
// Directed bench for float32_to_mxint8_quantizer (BLOCK_SIZE=32) with hand-computed blocks.
module tb_float32_to_mxint8_quantizer;

    localparam int BS = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                i_valid;
    logic [31:0]         i_float32;
    logic                o_ready;
    logic                o_valid;
    logic                i_ready;
    logic [7:0]          o_scale;
    logic [BS-1:0][7:0]  o_mxint8_elements;
    logic                o_is_NaN;
    logic                o_saturated;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;
    int unsigned k_last   = 0;

    logic [31:0]        blk [BS];
    logic [BS-1:0][7:0] ev;

    float32_to_mxint8_quantizer #(
        .BLOCK_SIZE   (BS),
        .SCALE_WIDTH  (8),
        .ELEM_WIDTH   (8),
        .FLOAT32_WIDTH(32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_valid          (i_valid),
        .i_float32        (i_float32),
        .o_ready          (o_ready),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_scale          (o_scale),
        .o_mxint8_elements(o_mxint8_elements),
        .o_is_NaN         (o_is_NaN),
        .o_saturated      (o_saturated)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req);
        checks++;
        assert (obs === req) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        i_valid   = 1'b1;
        i_float32 = w;
        while (!o_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk("send_ready_timeout", {255'd0, o_ready}, 256'd1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic send_block(input bit gaps);
        for (int i = 0; i < BS; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                i_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(blk[i]);
        end
        k_last = cyc;
        chk("ready_low_after_block", {255'd0, o_ready}, 256'd0);
    endtask

    task automatic wait_out();
        int n = 0;
        while (!o_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("o_valid_rise", {255'd0, o_valid}, 256'd1);
        chk("latency", 256'(cyc - k_last), 256'd33);
    endtask

    task automatic check_block(input string tag, input logic [7:0] scale, input logic nan,
                               input logic sat);
        chk({tag, "_scale"}, {248'd0, o_scale}, {248'd0, scale});
        chk({tag, "_nan"}, {255'd0, o_is_NaN}, {255'd0, nan});
        chk({tag, "_sat"}, {255'd0, o_saturated}, {255'd0, sat});
        chk({tag, "_elems"}, o_mxint8_elements, ev);
    endtask

    task automatic take_block();
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("valid_drop", {255'd0, o_valid}, 256'd0);
        chk("ready_back", {255'd0, o_ready}, 256'd1);
        chk("flags_clear", {254'd0, o_is_NaN, o_saturated}, 256'd0);
    endtask

    task automatic fill(input logic [31:0] w);
        for (int i = 0; i < BS; i++) blk[i] = w;
    endtask

    initial begin
        rst       = 1'b1;
        i_valid   = 1'b0;
        i_ready   = 1'b0;
        i_float32 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", {255'd0, o_ready}, 256'd1);
        chk("rst_valid", {255'd0, o_valid}, 256'd0);
        chk("rst_scale", {248'd0, o_scale}, 256'd0);
        chk("rst_elems", o_mxint8_elements, 256'd0);
        chk("rst_flags", {254'd0, o_is_NaN, o_saturated}, 256'd0);

        // 1: all 1.0
        fill(32'h3F800000);
        send_block(1'b0);
        wait_out();
        ev = {BS{8'h40}};
        check_block("c1", 8'h7F, 1'b0, 1'b0);
        take_block();

        // 2: mixed exponents, ties to even, negatives, -0
        fill(32'h00000000);
        blk[0] = 32'h40000000; blk[1] = 32'h3F000000; blk[2] = 32'h3C800000;
        blk[3] = 32'h3CC00000; blk[4] = 32'h3D400000; blk[5] = 32'hBD400000;
        blk[6] = 32'hBCC00000; blk[7] = 32'h80000000;
        send_block(1'b0);
        wait_out();
        ev = '0;
        ev[0] = 8'h40; ev[1] = 8'h10; ev[2] = 8'h00; ev[3] = 8'h01;
        ev[4] = 8'h02; ev[5] = 8'hFE; ev[6] = 8'hFF; ev[7] = 8'h00;
        check_block("c2", 8'h80, 1'b0, 1'b0);
        take_block();

        // 2 again with random input gaps: identical result
        send_block(1'b1);
        wait_out();
        check_block("c2gap", 8'h80, 1'b0, 1'b0);
        take_block();

        // 3: saturation both signs, -128 never produced
        fill(32'h00000000);
        blk[0] = 32'h3FFFFFFF; blk[1] = 32'hBF800000; blk[2] = 32'hBFFFFFFF;
        send_block(1'b0);
        wait_out();
        ev = '0;
        ev[0] = 8'h7F; ev[1] = 8'hC0; ev[2] = 8'h81;
        check_block("c3", 8'h7F, 1'b0, 1'b1);
        take_block();

        // 4: NaN, then +Inf in last slot with a would-saturate element
        fill(32'h3F800000);
        blk[5] = 32'h7FC00000;
        send_block(1'b0);
        wait_out();
        ev = '0;
        check_block("c4nan", 8'hFF, 1'b1, 1'b0);
        take_block();
        fill(32'h3F800000);
        blk[0]  = 32'h3FFFFFFF;
        blk[31] = 32'h7F800000;
        send_block(1'b0);
        wait_out();
        check_block("c4inf", 8'hFF, 1'b1, 1'b0);
        take_block();

        // 5: all denormal
        fill(32'h00000001);
        send_block(1'b0);
        wait_out();
        ev = '0;
        check_block("c5", 8'h00, 1'b0, 1'b0);
        take_block();

        // 6a: stall in OUT with i_valid NaN offered (must be ignored)
        fill(32'h3F800000);
        send_block(1'b0);
        wait_out();
        ev = {BS{8'h40}};
        for (int i = 0; i < 10; i++) begin
            i_valid   = 1'b1;
            i_float32 = 32'h7FC00000;
            @(posedge clk); #1;
            chk("hold_ready", {255'd0, o_ready}, 256'd0);
            chk("hold_valid", {255'd0, o_valid}, 256'd1);
        end
        i_valid = 1'b0;
        check_block("c6hold", 8'h7F, 1'b0, 1'b0);
        take_block();
        fill(32'h3F800000);
        send_block(1'b0);
        wait_out();
        check_block("c6after", 8'h7F, 1'b0, 1'b0);

        // 6b: async reset while block is presented
        #2;
        rst = 1'b1;
        #1;
        chk("rstout_valid", {255'd0, o_valid}, 256'd0);
        chk("rstout_ready", {255'd0, o_ready}, 256'd1);
        chk("rstout_scale", {248'd0, o_scale}, 256'd0);
        chk("rstout_elems", o_mxint8_elements, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 6c: reset after 10 NaN elements discards the partial block
        for (int i = 0; i < 10; i++) send(32'h7FC00000);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_ready", {255'd0, o_ready}, 256'd1);
        chk("rstmid_valid", {255'd0, o_valid}, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        fill(32'h3F800000);
        send_block(1'b0);
        wait_out();
        check_block("c6clean", 8'h7F, 1'b0, 1'b0);
        take_block();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
